// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared length codes, arbiter states, requester ids and RAM address width default
package mem_arbiter_pkg;
  localparam int ARB_ADDR_W = 17;
  localparam logic [1:0] MEM_LEN_B = 2'b00;
  localparam logic [1:0] MEM_LEN_H = 2'b01;
  localparam logic [1:0] MEM_LEN_W = 2'b10;
  typedef enum logic [1:0] {ARB_IDLE, ARB_READ, ARB_WRITE, ARB_FIN} arb_state_t;
  typedef enum logic {REQ_IF, REQ_MEM} req_t;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return (len == MEM_LEN_W || len == 2'b11) ? 3'd4 : len == MEM_LEN_H ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide RAM port between fetch (IF) and data (MEM), one byte per RAM cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              busy_o
);
  arb_state_t state_q, state_d;
  req_t req_q;
  logic we_q;
  logic [31:0] base_q, data_q, if_hold_q, mem_hold_q, addr_sum;
  logic [2:0] n_q, cnt_q;
  logic take_mem, take_if, mem_load_done, unused_sum_hi;
  assign take_mem = state_q == ARB_IDLE && mem_req_i;
  assign take_if = state_q == ARB_IDLE && !mem_req_i && if_req_i && !flush_i;
  assign addr_sum = base_q + 32'(cnt_q);
  assign unused_sum_hi = ^addr_sum[31:ADDR_W];
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: state_d = take_mem ? (mem_we_i ? ARB_WRITE : ARB_READ) : take_if ? ARB_READ : ARB_IDLE;
      ARB_READ: state_d = (req_q == REQ_IF && flush_i) ? ARB_IDLE : cnt_q == n_q ? ARB_FIN : ARB_READ;
      ARB_WRITE: state_d = cnt_q == n_q - 3'd1 ? ARB_FIN : ARB_WRITE;
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= ARB_IDLE;
    else state_q <= state_d;
  assign busy_o = state_q != ARB_IDLE;
  assign ram_wr_o = state_q == ARB_WRITE;
  // the extra READ cycle (cnt == N) only collects the last byte, so no address is driven then
  assign ram_addr_o = ((state_q == ARB_READ && cnt_q < n_q) || state_q == ARB_WRITE) ? addr_sum[ADDR_W-1:0] : '0;
  assign ram_dout_o = state_q == ARB_WRITE ? data_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
  assign if_done_o = state_q == ARB_FIN && req_q == REQ_IF;
  assign mem_done_o = state_q == ARB_FIN && req_q == REQ_MEM;
  assign mem_load_done = mem_done_o && !we_q;
  assign if_data_o = if_done_o ? data_q : if_hold_q;
  assign mem_rdata_o = mem_load_done ? data_q : mem_hold_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      req_q <= REQ_IF;
      we_q <= 1'b0;
      base_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      if_hold_q <= '0;
      mem_hold_q <= '0;
    end else begin
      if (take_mem || take_if) begin
        req_q <= take_mem ? REQ_MEM : REQ_IF;
        we_q <= take_mem && mem_we_i;
        base_q <= take_mem ? mem_addr_i : if_addr_i;
        n_q <= take_mem ? len_bytes(mem_len_i) : 3'd4;
        data_q <= (take_mem && mem_we_i) ? mem_wdata_i : '0;
        cnt_q <= '0;
      end
      if (state_q == ARB_READ || state_q == ARB_WRITE) cnt_q <= cnt_q + 3'd1;
      // RAM data lags its address by one cycle, so count k delivers byte k-1
      if (state_q == ARB_READ && cnt_q != 3'd0) data_q[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] <= ram_din_i;
      if (if_done_o) if_hold_q <= data_q;
      if (mem_load_done) mem_hold_q <= data_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic if_req, if_done, mem_req, mem_we, mem_done, flush, ram_wr, busy;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] mem_len;
  logic [16:0] ram_addr;
  logic [7:0] ram_dout, ram_din;
  logic [7:0] ram [0:(1<<17)-1];
  logic pre_we = 1'b0;
  logic [16:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  int checks = 0;
  int passes = 0;

  mem_arbiter #(.ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .flush_i(flush), .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout),
    .ram_din_i(ram_din), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_len = 0;
    mem_addr = 0; mem_wdata = 0; flush = 0;
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 0);
    chk("rst_ram", {14'd0, ram_wr, ram_addr}, 0);
    chk("rst_dout", 32'(ram_dout), 0);
    rst = 1'b1;
    tick;
    poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h10); poke(17'h103, 8'h00);
    poke(17'h0, 8'hef); poke(17'h1, 8'hbe); poke(17'h2, 8'had); poke(17'h3, 8'hde);
    poke(17'h2000, 8'hab);
    poke(17'h300, 8'h11); poke(17'h301, 8'h22); poke(17'h302, 8'h33); poke(17'h303, 8'h44);
    poke(17'h1fffe, 8'h01); poke(17'h1ffff, 8'h02);

    // IF word read
    if_req = 1; if_addr = 32'h100;
    tick; chk("if_a0", 32'(ram_addr), 32'h100); chk("if_busy", 32'(busy), 1);
    tick; chk("if_a1", 32'(ram_addr), 32'h101);
    tick; chk("if_a2", 32'(ram_addr), 32'h102);
    tick; chk("if_a3", 32'(ram_addr), 32'h103);
    tick; chk("if_t5_done", 32'(if_done), 0);
    tick; chk("if_done", 32'(if_done), 1); chk("if_data", if_data, 32'h00100513);
    chk("if_no_mem_done", 32'(mem_done), 0);
    if_req = 0;
    tick; chk("if_done_drop", 32'(if_done), 0); chk("if_data_hold", if_data, 32'h00100513);
    chk("if_idle", 32'(busy), 0);

    // simultaneous requests: MEM first
    if_req = 1; if_addr = 32'h0;
    mem_req = 1; mem_we = 0; mem_len = 2'b00; mem_addr = 32'h2000;
    tick; chk("sim_mem_a", 32'(ram_addr), 32'h2000);
    tick;
    tick; chk("sim_mem_done", 32'(mem_done), 1); chk("sim_mem_rdata", mem_rdata, 32'h000000ab);
    chk("sim_if_wait", 32'(if_done), 0);
    mem_req = 0;
    tick; chk("sim_t4_idle", 32'(busy), 0);
    tick; chk("sim_if_a0", 32'(ram_addr), 32'h0); chk("sim_if_busy", 32'(busy), 1);
    tick; chk("sim_if_a1", 32'(ram_addr), 32'h1);
    tick; tick; tick;
    tick; chk("sim_if_done", 32'(if_done), 1); chk("sim_if_data", if_data, 32'hdeadbeef);
    if_req = 0;
    tick;

    // halfword store
    mem_req = 1; mem_we = 1; mem_len = 2'b01; mem_addr = 32'h40; mem_wdata = 32'h00001234;
    tick; chk("st_b0", {ram_wr, 6'd0, ram_addr, ram_dout}, {1'b1, 6'd0, 17'h40, 8'h34});
    tick; chk("st_b1", {ram_wr, 6'd0, ram_addr, ram_dout}, {1'b1, 6'd0, 17'h41, 8'h12});
    tick; chk("st_done", 32'(mem_done), 1); chk("st_wr_off", 32'(ram_wr), 0);
    mem_req = 0; mem_we = 0;
    tick; chk("st_ram", {16'd0, ram[17'h41], ram[17'h40]}, 32'h1234);

    // flush during fetch
    if_req = 1; if_addr = 32'h100;
    tick; chk("fl_wr1", 32'(ram_wr), 0);
    tick; chk("fl_wr2", 32'(ram_wr), 0); flush = 1;
    tick; chk("fl_idle", 32'(busy), 0); chk("fl_no_done", 32'(if_done), 0);
    flush = 0; if_req = 0;
    tick; tick; tick;
    chk("fl_still_no_done", 32'(if_done), 0); chk("fl_data_kept", if_data, 32'hdeadbeef);

    // flush ignored during MEM word load
    mem_req = 1; mem_we = 0; mem_len = 2'b10; mem_addr = 32'h300;
    tick;
    tick; flush = 1;
    tick; chk("flm_busy", 32'(busy), 1);
    tick;
    tick; chk("flm_t5", 32'(mem_done), 0);
    tick; chk("flm_done", 32'(mem_done), 1); chk("flm_rdata", mem_rdata, 32'h44332211);
    mem_req = 0; flush = 0;
    tick;

    // reset in the middle of a word store
    mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h500; mem_wdata = 32'hcafef00d;
    tick; chk("rs_wr1", {ram_wr, 23'd0, ram_dout}, {1'b1, 23'd0, 8'h0d});
    tick; chk("rs_wr2", 32'(ram_wr), 1);
    rst = 0;
    #1;
    chk("rs_wr_drop", 32'(ram_wr), 0); chk("rs_busy", 32'(busy), 0); chk("rs_no_done", 32'(mem_done), 0);
    mem_req = 0; mem_we = 0;
    tick; chk("rs_rdata_clr", mem_rdata, 0);
    rst = 1;
    tick;
    mem_req = 1; mem_len = 2'b00; mem_addr = 32'h2000;
    tick; tick;
    tick; chk("rs_ld_done", 32'(mem_done), 1); chk("rs_ld_rdata", mem_rdata, 32'h000000ab);
    mem_req = 0;
    tick;

    // address wrap
    mem_req = 1; mem_len = 2'b11; mem_addr = 32'hfffffffe;
    tick; chk("wr_a0", 32'(ram_addr), 32'h1fffe);
    tick; chk("wr_a1", 32'(ram_addr), 32'h1ffff);
    tick; chk("wr_a2", 32'(ram_addr), 32'h0); chk("wr_a2_busy", 32'(busy), 1);
    tick; chk("wr_a3", 32'(ram_addr), 32'h1);
    tick;
    tick; chk("wr_done", 32'(mem_done), 1); chk("wr_rdata", mem_rdata, 32'hbeef0201);
    mem_req = 0;
    tick;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
